// File: rtl/inst_pkg.sv
// Shared types for the instruction dispatcher: instruction layout, config
// payloads split out of a 160-bit instruction, and the dispatcher state.
package inst_pkg;

  localparam int unsigned INST_LEN  = 160;
  localparam int unsigned ILC_CFG_W = 60;
  localparam int unsigned W2C_CFG_W = 77;
  localparam int unsigned ILC_LSB   = 0;
  localparam int unsigned W2C_LSB   = 60;

  // Instruction bits 59:0, MSB first
  typedef struct packed {
    logic        ilc_tofifo;      // 59
    logic        ilc_fromfifo;    // 58
    logic [7:0]  bsr_buffermux;   // 57:50
    logic [3:0]  bsr_iszero;      // 49:46
    logic [8:0]  ilc_linelen;     // 45:37
    logic        ilc_ispad;       // 36
    logic [35:0] ilc_st_addr;     // 35:0
  } ilc_cfg_t;

  // Instruction bits 136:60, MSB first
  typedef struct packed {
    logic [4:0]  bias_shift;      // 136:132
    logic [6:0]  bias_addr;       // 131:125
    logic        is_bb;           // 124
    logic [1:0]  w2c_valid_mac;   // 123:122
    logic [4:0]  w2c_shift_len;   // 121:117
    logic [8:0]  wb_st_rd_addr;   // 116:108
    logic        pooled_type;     // 107
    logic        w2c_pooled;      // 106
    logic [8:0]  w2c_linelen;     // 105:97
    logic [35:0] w2c_st_addr;     // 96:61
    logic        is_w2c_back;     // 60
  } w2c_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE_ILC,
    WAIT_ILC,
    ISSUE_W2C,
    WAIT_W2C,
    HALT
  } state_t;

  function automatic ilc_cfg_t get_ilc_cfg(input logic [INST_LEN-1:0] inst);
    return ilc_cfg_t'(inst[ILC_LSB +: ILC_CFG_W]);
  endfunction

  function automatic w2c_cfg_t get_w2c_cfg(input logic [INST_LEN-1:0] inst);
    return w2c_cfg_t'(inst[W2C_LSB +: W2C_CFG_W]);
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Per-phase watchdog: counts cycles while run is high, clears otherwise,
// flags expiry on the TIMEOUT-th consecutive cycle. TIMEOUT=0 disables it.
module dispatch_watchdog #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire_c,
  output logic err_timeout
);

  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;

  assign expire_c = (TIMEOUT != 0) && run && (cnt_q == LAST);

  // Counter restarts whenever the dispatcher is not waiting; the error is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt_q <= run ? cnt_q + WD_W'(1) : '0;
      if (expire_c) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: pops instructions from a show-ahead FIFO and runs
// the ILC and optional W2C start/done handshakes for each one.
module inst_dispatch
  import inst_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [INST_LEN-1:0]  instruct,
  input  logic                 inst_empty,
  output logic                 inst_req,
  output logic [ILC_CFG_W-1:0] ilc_cfg,
  output logic                 ilc_start,
  input  logic                 ilc_done,
  output logic [W2C_CFG_W-1:0] w2c_cfg,
  output logic                 w2c_start,
  input  logic                 w2c_done,
  output logic                 busy,
  output logic                 run_done,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     inst_count
);

  state_t           state_q, state_d;
  ilc_cfg_t         ilc_cfg_q;
  w2c_cfg_t         w2c_cfg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ilc_start_q, w2c_start_q, busy_q;
  logic             pop_c, run_done_c;
  logic             wd_run, wd_expire;
  logic             unused_reserved;

  // Reserved instruction bits are neither forwarded nor checked
  assign unused_reserved = ^instruct[INST_LEN-1:W2C_LSB+W2C_CFG_W];

  // Watchdog runs only while a WAIT state is still waiting for its done
  assign wd_run = ((state_q == WAIT_ILC) && !ilc_done) ||
                  ((state_q == WAIT_W2C) && !w2c_done);

  dispatch_watchdog #(
    .TIMEOUT     (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .run         (wd_run),
    .expire_c    (wd_expire),
    .err_timeout (err_timeout)
  );

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop_c      = 1'b0;
    run_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!inst_empty) begin
          pop_c   = 1'b1;
          state_d = ISSUE_ILC;
        end else begin
          run_done_c = 1'b1;
          state_d    = IDLE;
        end
      end
      ISSUE_ILC: state_d = WAIT_ILC;
      WAIT_ILC: begin
        if (ilc_done) begin
          if (w2c_cfg_q.is_w2c_back) begin
            state_d = ISSUE_W2C;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FETCH;
          end
        end else if (wd_expire) begin
          state_d = HALT;
        end
      end
      ISSUE_W2C: state_d = WAIT_W2C;
      WAIT_W2C: begin
        if (w2c_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH;
        end else if (wd_expire) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State, config latches and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ilc_cfg_q   <= '0;
      w2c_cfg_q   <= '0;
      cnt_q       <= '0;
      ilc_start_q <= 1'b0;
      w2c_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ilc_start_q <= (state_d == ISSUE_ILC);
      w2c_start_q <= (state_d == ISSUE_W2C);
      busy_q      <= (state_d != IDLE);
      if (pop_c) begin
        ilc_cfg_q <= get_ilc_cfg(instruct);
        w2c_cfg_q <= get_w2c_cfg(instruct);
      end
    end
  end

  assign inst_req   = pop_c;
  assign run_done   = run_done_c;
  assign ilc_cfg    = ilc_cfg_q;
  assign w2c_cfg    = w2c_cfg_q;
  assign ilc_start  = ilc_start_q;
  assign w2c_start  = w2c_start_q;
  assign busy       = busy_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch with a FIFO model and a config scoreboard.
module tb_inst_dispatch;

  logic         clk = 1'b0;
  logic         rst, start, ilc_done, w2c_done, inst_empty;
  logic [159:0] instruct;
  logic         inst_req, ilc_start, w2c_start, busy, run_done, err_timeout;
  logic [59:0]  ilc_cfg;
  logic [76:0]  w2c_cfg;
  logic [15:0]  inst_count;

  always #5 clk = ~clk;

  inst_dispatch #(
    .CNT_W       (16),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instruct    (instruct),
    .inst_empty  (inst_empty),
    .inst_req    (inst_req),
    .ilc_cfg     (ilc_cfg),
    .ilc_start   (ilc_start),
    .ilc_done    (ilc_done),
    .w2c_cfg     (w2c_cfg),
    .w2c_start   (w2c_start),
    .w2c_done    (w2c_done),
    .busy        (busy),
    .run_done    (run_done),
    .err_timeout (err_timeout),
    .inst_count  (inst_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_req, n_ilc, n_w2c, n_rd;
  int pop_cyc[$];
  logic [159:0] fifo[$];
  logic [59:0]  exp_ilc[$];
  logic [76:0]  exp_w2c[$];
  logic [59:0]  cur_ilc;
  bit           have_cur = 1'b0;
  logic         s_req, s_ilc, s_w2c, s_rd, s_busy, s_err;
  logic [15:0]  s_count;
  logic [159:0] inst_b;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void refresh();
    if (fifo.size() > 0) begin
      instruct   = fifo[0];
      inst_empty = 1'b0;
    end else begin
      instruct   = '0;
      inst_empty = 1'b1;
    end
  endfunction

  function automatic logic [159:0] make_inst(input bit w2c);
    logic [159:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    v[60] = w2c;
    return v;
  endfunction

  task automatic push_inst(input logic [159:0] v);
    fifo.push_back(v);
    exp_ilc.push_back(v[59:0]);
    exp_w2c.push_back(v[136:60]);
    refresh();
  endtask

  task automatic clear_counts();
    n_req = 0; n_ilc = 0; n_w2c = 0; n_rd = 0;
    pop_cyc.delete();
  endtask

  // Sample on the falling edge, advance the FIFO model after the rising edge
  task automatic tick();
    bit pop_now;
    @(negedge clk);
    s_req = inst_req; s_ilc = ilc_start; s_w2c = w2c_start; s_rd = run_done;
    s_busy = busy; s_err = err_timeout; s_count = inst_count;
    pop_now = (inst_req === 1'b1) && !inst_empty;
    if (inst_req === 1'b1) n_req++;
    if (run_done === 1'b1) n_rd++;
    if (w2c_start === 1'b1) n_w2c++;
    if (pop_now) begin
      pop_cyc.push_back(cyc);
      if (have_cur) check("cfg_stable", 160'(ilc_cfg), 160'(cur_ilc));
    end
    if (ilc_start === 1'b1) begin
      n_ilc++;
      check("sb_nonempty", 160'(exp_ilc.size() != 0), 160'(1));
      if (exp_ilc.size() != 0) begin
        cur_ilc  = exp_ilc.pop_front();
        have_cur = 1'b1;
        check("ilc_cfg", 160'(ilc_cfg), 160'(cur_ilc));
        check("w2c_cfg", 160'(w2c_cfg), 160'(exp_w2c.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now) void'(fifo.pop_front());
    refresh();
  endtask

  // which: 0 = ilc_start, 1 = w2c_start, 2 = run_done
  task automatic wait_until(input int which, input string tag);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 40) begin
      tick();
      n++;
      hit = (which == 0) ? s_ilc : (which == 1) ? s_w2c : s_rd;
    end
    check({tag, "_seen"}, 160'(hit), 160'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ilc_done = 1'b0; w2c_done = 1'b0;
    refresh();
    tick(); tick();
    check("rst_busy", 160'(s_busy), 160'(0));
    check("rst_ilc_start", 160'(s_ilc), 160'(0));
    check("rst_count", 160'(s_count), 160'(0));
    check("rst_err", 160'(s_err), 160'(0));
    check("rst_ilc_cfg", 160'(ilc_cfg), 160'(0));
    check("rst_w2c_cfg", 160'(w2c_cfg), 160'(0));
    rst = 1'b0;

    // Two instructions, second requests W2C
    clear_counts();
    push_inst(make_inst(1'b0));
    inst_b = make_inst(1'b1);
    push_inst(inst_b);
    pulse_start();
    wait_until(0, "t1_ilc_a");
    repeat (3) tick();
    ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    wait_until(0, "t1_ilc_b");
    repeat (3) tick();
    ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    wait_until(1, "t1_w2c");
    repeat (5) tick();
    w2c_done = 1'b1; tick(); w2c_done = 1'b0;
    tick();
    check("t1_run_done", 160'(s_rd), 160'(1));
    check("t1_count", 160'(s_count), 160'(2));
    check("t1_n_req", 160'(n_req), 160'(2));
    check("t1_n_ilc", 160'(n_ilc), 160'(2));
    check("t1_n_w2c", 160'(n_w2c), 160'(1));
    check("t1_w2c_cfg_b", 160'(w2c_cfg), 160'(inst_b[136:60]));
    tick();
    check("t1_idle_busy", 160'(s_busy), 160'(0));

    // Start with an empty FIFO
    clear_counts();
    pulse_start();
    tick();
    check("t2_run_done", 160'(s_rd), 160'(1));
    check("t2_no_req", 160'(s_req), 160'(0));
    check("t2_count", 160'(s_count), 160'(0));

    // Done in the issue cycle and stray w2c_done while waiting are ignored
    clear_counts();
    push_inst(make_inst(1'b0));
    pulse_start();
    tick();
    ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    check("t3_ilc_start", 160'(s_ilc), 160'(1));
    w2c_done = 1'b1; tick(); w2c_done = 1'b0;
    repeat (3) tick();
    check("t3_still_busy", 160'(s_busy), 160'(1));
    check("t3_count_held", 160'(s_count), 160'(0));
    check("t3_no_run_done", 160'(n_rd), 160'(0));
    ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    tick();
    check("t3_run_done", 160'(s_rd), 160'(1));
    check("t3_count", 160'(s_count), 160'(1));

    // Back-to-back instructions with the fastest ILC turnaround
    clear_counts();
    for (int i = 0; i < 3; i++) push_inst(make_inst(1'b0));
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_until(0, "t4_ilc");
      ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    end
    tick();
    check("t4_run_done", 160'(s_rd), 160'(1));
    check("t4_count", 160'(s_count), 160'(3));
    check("t4_pops", 160'(pop_cyc.size()), 160'(3));
    if (pop_cyc.size() == 3) begin
      check("t4_gap0", 160'(pop_cyc[1] - pop_cyc[0]), 160'(3));
      check("t4_gap1", 160'(pop_cyc[2] - pop_cyc[1]), 160'(3));
    end

    // Reset while waiting for W2C, then a clean rerun
    clear_counts();
    push_inst(make_inst(1'b1));
    push_inst(make_inst(1'b0));
    pulse_start();
    wait_until(0, "t5_ilc");
    ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    wait_until(1, "t5_w2c");
    tick();
    rst = 1'b1; w2c_done = 1'b1; tick(); rst = 1'b0; w2c_done = 1'b0;
    fifo.delete(); exp_ilc.delete(); exp_w2c.delete();
    have_cur = 1'b0;
    refresh();
    tick();
    check("t5_busy", 160'(s_busy), 160'(0));
    check("t5_req", 160'(s_req), 160'(0));
    check("t5_w2c_start", 160'(s_w2c), 160'(0));
    check("t5_run_done", 160'(s_rd), 160'(0));
    check("t5_count", 160'(s_count), 160'(0));
    check("t5_ilc_cfg", 160'(ilc_cfg), 160'(0));
    check("t5_w2c_cfg", 160'(w2c_cfg), 160'(0));
    clear_counts();
    push_inst(make_inst(1'b1));
    pulse_start();
    wait_until(0, "t5r_ilc");
    ilc_done = 1'b1; tick(); ilc_done = 1'b0;
    wait_until(1, "t5r_w2c");
    w2c_done = 1'b1; tick(); w2c_done = 1'b0;
    tick();
    check("t5r_run_done", 160'(s_rd), 160'(1));
    check("t5r_count", 160'(s_count), 160'(1));
    check("t5r_n_req", 160'(n_req), 160'(1));

    // Watchdog: ilc_done never returns
    clear_counts();
    push_inst(make_inst(1'b0));
    pulse_start();
    wait_until(0, "t6_ilc");
    repeat (8) tick();
    check("t6_err_early", 160'(s_err), 160'(0));
    push_inst(make_inst(1'b0));
    tick();
    check("t6_err_set", 160'(s_err), 160'(1));
    check("t6_busy", 160'(s_busy), 160'(1));
    repeat (5) tick();
    check("t6_err_sticky", 160'(s_err), 160'(1));
    check("t6_halt_busy", 160'(s_busy), 160'(1));
    check("t6_n_req", 160'(n_req), 160'(1));
    check("t6_n_ilc", 160'(n_ilc), 160'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    check("t6_err_cleared", 160'(s_err), 160'(0));
    check("t6_idle", 160'(s_busy), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
